// File: rtl/synch_down_counter.sv
// -----------------------------------------------------------------------------
// synch_down_counter
//   Loadable synchronous down counter with terminal-count pulse, one-shot and
//   auto-reload modes. A three-state control FSM (IDLE / RUN / DONE) tracks
//   whether a count is running, has finished, or is idle.
//
// Optional feature macro: SYNCH_DOWN_PRESCALE_EN
//   When defined, a prescaler makes every PRESCALE-th enabled RUN cycle a
//   step. When undefined, every enabled RUN cycle is a step.
//
// Parameters:
//   WIDTH     counter / load-value width in bits (>= 2)
//   PRESCALE  enabled cycles per step when the prescaler is built (2..256)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset, highest priority
//   en           count enable
//   load         load strobe (priority over en)
//   load_val     start value, also captured as the reload value
//   auto_reload  1 = periodic, 0 = one-shot (looked at when Q==1 steps)
//   Q            current count (registered)
//   tc           one-cycle terminal-count pulse (registered)
//   busy         high while in RUN (registered)
//   done         high while in DONE (registered)
// -----------------------------------------------------------------------------
module synch_down_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             step_s;

  // Elaboration-time guard on parameter ranges.
  if ((WIDTH < 2) || (PRESCALE < 2) || (PRESCALE > 256)) begin : g_param_check
    $error("synch_down_counter: WIDTH must be >= 2 and PRESCALE in 2..256");
  end

`ifdef SYNCH_DOWN_PRESCALE_EN
  localparam int            PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  // Prescaler next value and step strobe: counts enabled RUN cycles only.
  always_comb begin
    pre_d  = pre_q;
    step_s = 1'b0;
    if (load) begin
      pre_d = {PW{1'b0}};
    end else if (state_q == ST_RUN) begin
      if (en) begin
        if (pre_q == PRE_LAST) begin
          // Wrap doubles as the clear on entry to DONE after the last step.
          pre_d  = {PW{1'b0}};
          step_s = 1'b1;
        end else begin
          pre_d  = pre_q + PW'(1);
          step_s = 1'b0;
        end
      end else begin
        pre_d = pre_q;
      end
    end else begin
      pre_d = {PW{1'b0}};
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= {PW{1'b0}};
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  // Without the prescaler every enabled cycle is a step.
  assign step_s = en;
`endif

  // Next-state, count and terminal-count logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      // Load discards any pending terminal count.
      cnt_d    = load_val;
      reload_d = load_val;
      if (load_val != {WIDTH{1'b0}}) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (step_s) begin
            if (cnt_q == WIDTH'(1)) begin
              cnt_d = {WIDTH{1'b0}};
              tc_d  = 1'b1;
              if (auto_reload) begin
                state_d = ST_RUN;
              end else begin
                state_d = ST_DONE;
              end
            end else if (cnt_q == {WIDTH{1'b0}}) begin
              // Only reachable in auto-reload: the zero cycle closes the period.
              cnt_d = reload_q;
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_IDLE: begin
          cnt_d = cnt_q;
        end
        ST_DONE: begin
          cnt_d = cnt_q;
        end
        default: begin
          // Unreachable encoding: recover to a quiet idle state.
          state_d = ST_IDLE;
          cnt_d   = {WIDTH{1'b0}};
        end
      endcase
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, count and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {WIDTH{1'b0}};
      reload_q <= {WIDTH{1'b0}};
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Q    = cnt_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_synch_down_counter.sv
// -----------------------------------------------------------------------------
// tb_synch_down_counter
//   Scoreboard bench: the stimulus process drives one cycle of inputs, computes
//   the expected registered outputs with a behavioural model and queues them;
//   a monitor pops one entry after each rising edge and compares.
// -----------------------------------------------------------------------------
module tb_synch_down_counter;

  localparam int W = 4;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] q_o;
  logic         tc_o, busy_o, done_o;

  synch_down_counter #(.WIDTH(W), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .auto_reload(auto_reload), .Q(q_o), .tc(tc_o), .busy(busy_o), .done(done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: plain integers, mode 0 = idle, 1 = running, 2 = finished.
  int m_cnt = 0, m_rel = 0, m_mode = 0, m_pre = 0;
  bit m_tc = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic void model_step(input bit r, input bit e, input bit l,
                                     input int lv, input bit ar);
    bit do_step;
    m_tc = 1'b0;
    if (r) begin
      m_cnt = 0; m_rel = 0; m_mode = 0; m_pre = 0;
    end else if (l) begin
      m_cnt = lv; m_rel = lv; m_pre = 0;
      m_mode = (lv != 0) ? 1 : 0;
    end else if (m_mode == 1 && e) begin
`ifdef SYNCH_DOWN_PRESCALE_EN
      m_pre = m_pre + 1;
      do_step = (m_pre == P);
      if (do_step) m_pre = 0;
`else
      do_step = 1'b1;
`endif
      if (do_step) begin
        if (m_cnt == 0) begin
          m_cnt = m_rel;
        end else if (m_cnt == 1) begin
          m_cnt = 0;
          m_tc  = 1'b1;
          if (!ar) m_mode = 2;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  endfunction

  // Drive one cycle of inputs and queue the response expected after the edge.
  task automatic drive(input bit r, input bit e, input bit l, input int lv, input bit ar);
    exp_t x;
    @(negedge clk);
    reset = r; en = e; load = l; load_val = W'(lv); auto_reload = ar;
    model_step(r, e, l, lv, ar);
    x.q    = W'(m_cnt);
    x.tc   = m_tc;
    x.busy = (m_mode == 1);
    x.done = (m_mode == 2);
    exp_q.push_back(x);
  endtask

  // Monitor: one registered output set per clock, compared #1 after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("Q",    int'(q_o),    int'(x.q));
        chk("tc",   int'(tc_o),   int'(x.tc));
        chk("busy", int'(busy_o), int'(x.busy));
        chk("done", int'(done_o), int'(x.done));
      end
    end
  end

  initial begin
    int lv;
    bit ar;
    int waitc;

    // Reset with en and load asserted.
    drive(1, 1, 1, 9, 0);
    drive(1, 1, 1, 9, 0);

    // One-shot from 5, then idle in DONE.
    drive(0, 0, 1, 5, 0);
    repeat (16 + 5 * P) drive(0, 1, 0, 0, 0);

    // Auto-reload from 3.
    drive(0, 0, 1, 3, 1);
    repeat (12 * P) drive(0, 1, 0, 0, 1);

    // Toggling enable from 9.
    drive(0, 0, 1, 9, 0);
    for (int i = 0; i < 24 * P; i++) drive(0, (i % 2) == 0, 0, 0, 0);

    // Load wins over a terminal step at Q==1.
    drive(0, 0, 1, 2, 0);
    repeat (P) drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 7, 0);
    repeat (3) drive(0, 1, 0, 0, 0);

    // Load of zero: idle, never a tc.
    drive(0, 0, 1, 0, 1);
    repeat (8) drive(0, 1, 0, 0, 1);

    // Reset mid-count at Q==2.
    drive(0, 0, 1, 3, 0);
    repeat (P) drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 0);

    // Auto-reload dropped while Q==0: reload still happens, one-shot next.
    drive(0, 0, 1, 2, 1);
    repeat (2 * P) drive(0, 1, 0, 0, 1);
    repeat (6 * P) drive(0, 1, 0, 0, 0);

    // Randomized traffic.
    ar = 1'b0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 19) == 0) ar = ~ar;
      if ($urandom_range(0, 2) == 0) lv = $urandom_range(0, 15);
      else lv = $urandom_range(0, 3);
      drive($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 14) == 0, lv, ar);
    end
    drive(0, 0, 0, 0, 0);

    waitc = 0;
    while (exp_q.size() != 0 && waitc < 10) begin
      @(posedge clk);
      waitc++;
    end
    #2;
    chk("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/synch_down_counter.md
Name: synch_down_counter

Overview:
Loadable synchronous down counter with terminal-count detection, one-shot and auto-reload modes. It provides the countdown side of the counter family, decrementing toward zero, and is used for timeouts, delay generation and periodic ticks in lab designs. A small control FSM tracks whether a count is running, finished, or idle.

Parameters:
- WIDTH, 4, counter and load-value width in bits (WIDTH >= 2).
- PRESCALE, 4, enabled cycles per decrement. Used only when SYNCH_DOWN_PRESCALE_EN is defined; legal range 2..256.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; one clock, sampled on the rising edge of clk.
- en  input  1  count enable; sampled each rising edge.
- load  input  1  load strobe; sampled each rising edge.
- load_val  input  WIDTH  start value; also captured as the reload value.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled live.
- Q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered; high for exactly one cycle.
- busy  output  1  high while state = RUN.
- done  output  1  high while state = DONE (one-shot finished).

Behaviour:
- All outputs are registered. There is no combinational path from any input to any output.
- Reset: Q=0, reload_reg=0, state=IDLE, tc=0, busy=0, done=0. Reset has priority over every other input.
- Priority below reset: load > en.
- Load, accepted in any state:
  - Q<=load_val and reload_reg<=load_val.
  - state<=RUN if load_val!=0. If load_val==0, state<=IDLE and no tc is generated.
  - tc<=0.
- IDLE: en is ignored and Q holds.
- DONE: en is ignored, Q holds at 0 and done=1. Only load or reset leaves DONE.
- RUN, en=0: Q holds and tc<=0.
- RUN, en=1, Q>1: Q<=Q-1 and tc<=0.
- RUN, en=1, Q==1:
  - Q<=0 and tc<=1, so tc is high in the cycle in which Q first reads 0.
  - If auto_reload=0, state<=DONE. If auto_reload=1, stay in RUN.
- RUN, en=1, Q==0 (only reachable in auto-reload mode): Q<=reload_reg and tc<=0.
  - Auto-reload period is therefore reload_reg+1 enabled cycles, with one tc per period.
- auto_reload is sampled only at the Q==1 decision point. Deasserting it while Q==0 in RUN still reloads on the next enabled cycle, and the one-shot takes effect at the next Q==1.
- The count never wraps from 0 to all-ones. Underflow is impossible by construction.
- Width rule: all arithmetic is WIDTH bits unsigned. Maximum load is 2^WIDTH-1, which gives a one-shot of 2^WIDTH-1 enabled cycles.
- Reset mid-count: on the next edge the state is as after reset, and no tc is emitted.
- Load mid-count: restarts immediately from the new value. Any pending terminal count is discarded, and no tc fires on that edge even if Q==1 and en=1.

Optional Feature:
- Macro: SYNCH_DOWN_PRESCALE_EN.
- When defined, an internal counter of ceil(log2(PRESCALE)) bits counts enabled RUN cycles. A decrement or reload step occurs only when the prescaler reaches PRESCALE-1; the prescaler then wraps to 0. All of the RUN rules above apply to these step cycles instead of raw en cycles.
- The prescaler clears on reset, on load, and on entry to DONE or IDLE.
- tc remains a single clk-cycle pulse.
- When the macro is not defined, there is no prescaler logic and every enabled RUN cycle is a step.

Test Plan:
1. reset=1 for 2 cycles while en=1 and load=1 -> Q=0, tc=0, busy=0, done=0 throughout.
2. load_val=5, auto_reload=0, then en=1 continuously -> Q sequence 5,4,3,2,1,0. tc is high only in the cycle Q=0. done rises with Q=0 and Q stays 0 for 10 further cycles.
3. load_val=3, auto_reload=1, en=1 for 12 cycles -> Q sequence 3,2,1,0,3,2,1,0,3,... with tc pulses exactly 4 cycles apart and busy=1 throughout.
4. load_val=9, en toggling 1/0 each cycle -> Q decrements only on en=1 cycles; tc occurs after 9 enabled cycles.
5. Boundary cases:
   - Q=1 with en=1, load=1 and load_val=7 on the same edge -> Q=7 and tc=0.
   - load_val=0 -> state IDLE, tc never pulses.
   - Assert reset while Q=2 -> Q=0, no tc.
6. With SYNCH_DOWN_PRESCALE_EN defined and PRESCALE=4, load_val=2, en=1 -> Q holds 4 cycles per value (2,2,2,2,1,1,1,1,0). tc is a single-cycle pulse at the first Q=0.
